sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one SRAM_Controller backend between two requesters: port 0 (instruction fetch) and port 1 (data, MEM stage).
- Each requester sees the same level-request/ready contract the pipeline already uses against SRAM_Controller, so a requester's freeze can be driven by ~p*_ready.
- Grants one access at a time, round-robin by default.
- Latches the winning request, sequences the backend until completion, then returns read data to the winner.

Parameters:
- ADDR_W, 32, address width on both requester ports and the backend.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- p0_read_en  input  1  port 0 read request (level).
- p0_write_en  input  1  port 0 write request (level).
- p0_address  input  ADDR_W  port 0 address.
- p0_write_data  input  DATA_W  port 0 write data.
- p0_read_data  output  DATA_W  port 0 read result.
- p0_ready  output  1  port 0 ready; low = requester must freeze.
- p1_read_en, p1_write_en, p1_address, p1_write_data, p1_read_data, p1_ready: same as port 0, for port 1.
- mem_read_en  output  1  backend read enable (registered).
- mem_write_en  output  1  backend write enable (registered).
- mem_address  output  ADDR_W  backend address (registered).
- mem_write_data  output  DATA_W  backend write data (registered).
- mem_read_data  input  DATA_W  backend read data, valid when mem_ready is high in an active access.
- mem_ready  input  1  backend ready; low while an access is in progress, high in its completion cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=0, grant=0.
  - mem_read_en=0, mem_write_en=0, mem_address=0, mem_write_data=0.
  - p0_read_data=0, p1_read_data=0.
  - p0_ready and p1_ready follow their combinational rule (both 1 when no request is pending).
- States: IDLE, BUSY.
- IDLE:
  - A port is requesting when read_en|write_en.
  - None requesting: stay in IDLE.
  - Otherwise pick a winner:
    - Only one requesting: that port.
    - Both requesting: the port != last_grant.
  - On the next edge: grant=winner; latch address and write_data into mem_*; mem_write_en=winner.write_en; mem_read_en=winner.read_en & ~winner.write_en (write wins if both asserted); go to BUSY.
- BUSY:
  - Completion = mem_ready==1 in this state.
  - On completion: pX_ready=1 combinationally for the granted port; for a read, pX_read_data is driven from mem_read_data combinationally and also registered into a hold register.
  - Next edge after completion: clear mem_*_en, last_grant=grant, go to IDLE.
  - No new grant is made in the completion cycle, so there is a minimum 1-cycle IDLE gap between accesses.
- Ready rule, per port, combinational:
  - ready=1 if the port is not requesting.
  - ready=1 if it is the granted port in its BUSY completion cycle.
  - ready=0 otherwise, including the IDLE cycle in which the request is first seen.
- pX_read_data outside the completion cycle holds the last value returned to that port.
- Latency: request seen at IDLE cycle N → backend enables high at N+1 → ready at N+1+k, where k is backend access cycles (k>=1) → IDLE at N+2+k.
- A requester must hold its enables and address until it sees ready. Because the arbiter drives the backend from latched copies, a withdrawn request does not abort the access; it still completes and is discarded.
- Reset mid-access: backend enables drop immediately and the access is abandoned; the backend sees enables low.
- A port re-asserting in the cycle right after its completion is a new access and re-arbitrates fairly.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: when both ports request in IDLE, port 1 (data) always wins; last_grant is still updated but ignored. Port 0 can starve under back-to-back data traffic.
- Undefined: round-robin as above.

Decomposition:
- Package sram_arb_pkg holds:
  - State enum: ARB_IDLE=1'b0, ARB_BUSY=1'b1.
  - Port index constants: ARB_PORT_IF=0, ARB_PORT_MEM=1.
  - Default ADDR_W and DATA_W.
- One sub-module, rr_pick2: combinational 2-way picker. Inputs: req[1:0], last, fixed_prio. Outputs: winner, any. Instantiated once.
- All sequential logic stays in sram_arbiter.

Test Plan:
- Reset then idle: rst=0→1, no requests → mem_*_en=0, p0_ready=p1_ready=1, p*_read_data=0.
- Single read: p0_read_en=1 at 0x0000_0010, backend k=3 returning 0xDEADBEEF → mem_read_en high 1 cycle after request; p0_ready=0 for 4 cycles, then 1 with p0_read_data=0xDEADBEEF; p1_ready stays 1.
- Contention after reset: p0 read 0x20 and p1 write 0x40 data 0x12345678 in the same cycle → port 1 served first (last_grant=0), mem_write_en=1, mem_address=0x40; after its completion plus the IDLE gap, port 0 is granted.
- Fairness: both ports request continuously for 6 accesses → grants alternate 1,0,1,0,1,0; with ARB_FIXED_PRIO_EN → 1,1,1,1,1,1 and p0_ready stays 0.
- Read+write both on p1 (0x80, 0xCAFEF00D) → mem_write_en=1, mem_read_en=0.
- Mid-access reset: assert rst=0 during BUSY → mem_read_en and mem_write_en fall in the same cycle; after release, state=IDLE and the pending request is re-arbitrated.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
package sram_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Requester indices: port 0 is instruction fetch, port 1 is the MEM-stage data port
    localparam logic ARB_PORT_IF  = 1'b0;
    localparam logic ARB_PORT_MEM = 1'b1;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// rtl/sram_arbiter_rr_pick2.sv - combinational two-way round-robin / fixed-priority picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       winner,
    output logic       any
);

    assign any = |req;

    // A lone requester always wins; on a tie, alternate away from the last grant
    // unless fixed priority hands it to port 1.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = fixed_prio ? 1'b1 : ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM controller between fetch and data ports (ARB_FIXED_PRIO_EN selects fixed priority)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_read_en,
    input  logic              p0_write_en,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_write_data,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_ready,
    input  logic              p1_read_en,
    input  logic              p1_write_en,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_write_data,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_ready,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready
);

`ifdef ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              mem_read_en_q;
    logic              mem_write_en_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_write_data_q;
    logic [DATA_W-1:0] p0_hold_q;
    logic [DATA_W-1:0] p1_hold_q;

    logic [1:0]        req;
    logic              winner;
    logic              any_req;
    logic              done;
    logic              rd_done;

    assign req[0] = p0_read_en | p0_write_en;
    assign req[1] = p1_read_en | p1_write_en;

    rr_pick2 u_pick (
        .req        (req),
        .last       (last_grant_q),
        .fixed_prio (FIXED_PRIO),
        .winner     (winner),
        .any        (any_req)
    );

    // Completion cycle of the current access; only reads return data
    assign done    = (state_q == ARB_BUSY) & mem_ready;
    assign rd_done = done & mem_read_en_q;

    // Grant, sequence the backend from latched copies, and capture returned read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ARB_IDLE;
            grant_q          <= ARB_PORT_IF;
            last_grant_q     <= ARB_PORT_IF;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            p0_hold_q        <= '0;
            p1_hold_q        <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        state_q <= ARB_BUSY;
                        if (winner == ARB_PORT_MEM) begin
                            mem_address_q    <= p1_address;
                            mem_write_data_q <= p1_write_data;
                            mem_write_en_q   <= p1_write_en;
                            mem_read_en_q    <= p1_read_en & ~p1_write_en;
                        end else begin
                            mem_address_q    <= p0_address;
                            mem_write_data_q <= p0_write_data;
                            mem_write_en_q   <= p0_write_en;
                            mem_read_en_q    <= p0_read_en & ~p0_write_en;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready) begin
                        mem_read_en_q  <= 1'b0;
                        mem_write_en_q <= 1'b0;
                        last_grant_q   <= grant_q;
                        state_q        <= ARB_IDLE;
                        if (mem_read_en_q) begin
                            if (grant_q == ARB_PORT_MEM) begin
                                p1_hold_q <= mem_read_data;
                            end else begin
                                p0_hold_q <= mem_read_data;
                            end
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign mem_read_en    = mem_read_en_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

    // A port may proceed when idle or in the completion cycle of its own access
    assign p0_ready = ~req[0] | (done & (grant_q == ARB_PORT_IF));
    assign p1_ready = ~req[1] | (done & (grant_q == ARB_PORT_MEM));

    assign p0_read_data = (rd_done && grant_q == ARB_PORT_IF)  ? mem_read_data : p0_hold_q;
    assign p1_read_data = (rd_done && grant_q == ARB_PORT_MEM) ? mem_read_data : p1_hold_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int K = 3;

    logic        clk;
    logic        rst;
    logic        p0_read_en, p0_write_en;
    logic [31:0] p0_address, p0_write_data, p0_read_data;
    logic        p0_ready;
    logic        p1_read_en, p1_write_en;
    logic [31:0] p1_address, p1_write_data, p1_read_data;
    logic        p1_ready;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_ready;

    int          n_checks;
    int          n_fail;
    int          bk_cnt;
    logic [31:0] bk_rdata;

    sram_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .p0_read_en     (p0_read_en),
        .p0_write_en    (p0_write_en),
        .p0_address     (p0_address),
        .p0_write_data  (p0_write_data),
        .p0_read_data   (p0_read_data),
        .p0_ready       (p0_ready),
        .p1_read_en     (p1_read_en),
        .p1_write_en    (p1_write_en),
        .p1_address     (p1_address),
        .p1_write_data  (p1_write_data),
        .p1_read_data   (p1_read_data),
        .p1_ready       (p1_ready),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backend model: k cycles with enables high and ready low, then one completion cycle
    initial bk_cnt = 0;
    always @(posedge clk) begin
        if ((mem_read_en | mem_write_en) && !mem_ready) bk_cnt <= bk_cnt + 1;
        else bk_cnt <= 0;
    end
    assign mem_ready     = (mem_read_en | mem_write_en) && (bk_cnt == K);
    assign mem_read_data = bk_rdata;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        p0_read_en = 0; p0_write_en = 0; p0_address = 0; p0_write_data = 0;
        p1_read_en = 0; p1_write_en = 0; p1_address = 0; p1_write_data = 0;
    endtask

    task automatic do_reset;
        clear_reqs();
        rst = 1'b0;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read_en got %0h want 0", mem_read_en); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write_en got %0h want 0", mem_write_en); end
        n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address got %0h want 0", mem_address); end
        n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_write_data got %0h want 0", mem_write_data); end
        n_checks++; if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_p0_ready got %0h want 1", p0_ready); end
        n_checks++; if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_p1_ready got %0h want 1", p1_ready); end
        n_checks++; if (p0_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_p0_read_data got %0h want 0", p0_read_data); end
        n_checks++; if (p1_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_p1_read_data got %0h want 0", p1_read_data); end
        repeat (3) step();
        n_checks++; if ((mem_read_en | mem_write_en) !== 1'b0) begin n_fail++; $display("FAIL idle_no_enable got %0h want 0", mem_read_en | mem_write_en); end
    endtask

    task automatic test_single_read;
        int low_cycles;
        bk_rdata = 32'hDEAD_BEEF;
        p0_read_en = 1; p0_address = 32'h10;
        #1;
        low_cycles = 0;
        if (p0_ready === 1'b0) low_cycles++;
        step();
        n_checks++; if (mem_read_en !== 1'b1) begin n_fail++; $display("FAIL single_mem_read_en got %0h want 1", mem_read_en); end
        n_checks++; if (mem_address !== 32'h10) begin n_fail++; $display("FAIL single_mem_address got %0h want 10", mem_address); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL single_mem_write_en got %0h want 0", mem_write_en); end
        if (p0_ready === 1'b0) low_cycles++;
        for (int i = 0; i < 2; i++) begin
            step();
            if (p0_ready === 1'b0) low_cycles++;
            n_checks++; if (p1_ready !== 1'b1) begin n_fail++; $display("FAIL single_p1_ready got %0h want 1", p1_ready); end
        end
        n_checks++; if (low_cycles !== 4) begin n_fail++; $display("FAIL single_p0_low_cycles got %0d want 4", low_cycles); end
        step();
        n_checks++; if (p0_ready !== 1'b1) begin n_fail++; $display("FAIL single_p0_ready got %0h want 1", p0_ready); end
        n_checks++; if (p0_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_p0_read_data got %0h want deadbeef", p0_read_data); end
        p0_read_en = 0;
        step();
        bk_rdata = 32'h0;
        #1;
        n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL single_en_cleared got %0h want 0", mem_read_en); end
        n_checks++; if (p0_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold got %0h want deadbeef", p0_read_data); end
    endtask

    task automatic test_contention;
        bit got;
        do_reset();
        bk_rdata = 32'h0BAD_F00D;
        p0_read_en = 1; p0_address = 32'h20;
        p1_write_en = 1; p1_address = 32'h40; p1_write_data = 32'h1234_5678;
        step();
        n_checks++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL cont_mem_write_en got %0h want 1", mem_write_en); end
        n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL cont_mem_read_en got %0h want 0", mem_read_en); end
        n_checks++; if (mem_address !== 32'h40) begin n_fail++; $display("FAIL cont_mem_address got %0h want 40", mem_address); end
        n_checks++; if (mem_write_data !== 32'h1234_5678) begin n_fail++; $display("FAIL cont_mem_write_data got %0h want 12345678", mem_write_data); end
        n_checks++; if (p0_ready !== 1'b0) begin n_fail++; $display("FAIL cont_p0_waits got %0h want 0", p0_ready); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (p1_ready === 1'b1) got = 1;
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL cont_p1_timeout got %0h want 1", got); end
        n_checks++; if (p0_ready !== 1'b0) begin n_fail++; $display("FAIL cont_p0_not_ready got %0h want 0", p0_ready); end
        p1_write_en = 0;
        step();
        n_checks++; if ((mem_read_en | mem_write_en) !== 1'b0) begin n_fail++; $display("FAIL cont_idle_gap got %0h want 0", mem_read_en | mem_write_en); end
        step();
        n_checks++; if (mem_read_en !== 1'b1) begin n_fail++; $display("FAIL cont_p0_granted got %0h want 1", mem_read_en); end
        n_checks++; if (mem_address !== 32'h20) begin n_fail++; $display("FAIL cont_p0_address got %0h want 20", mem_address); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (p0_ready === 1'b1) got = 1;
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL cont_p0_timeout got %0h want 1", got); end
        n_checks++; if (p0_read_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL cont_p0_read_data got %0h want badf00d", p0_read_data); end
        clear_reqs();
        step();
    endtask

    task automatic test_fairness;
        logic [5:0] grants;
        logic [5:0] expect_g;
        int         n;
        logic       prev_en;
        logic       p0_saw_ready;
        do_reset();
        p0_read_en = 1; p0_address = 32'h100;
        p1_write_en = 1; p1_address = 32'h200; p1_write_data = 32'h55;
        n = 0; prev_en = 0; p0_saw_ready = 0; grants = '0;
`ifdef ARB_FIXED_PRIO_EN
        expect_g = 6'b111111;
`else
        expect_g = 6'b010101;
`endif
        for (int c = 0; c < 80 && n < 6; c++) begin
            step();
            if (p0_ready === 1'b1) p0_saw_ready = 1;
            if ((mem_read_en | mem_write_en) && !prev_en) begin
                grants[n] = (mem_address == 32'h200);
                n++;
            end
            prev_en = mem_read_en | mem_write_en;
        end
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL fair_count got %0d want 6", n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (grants[i] !== expect_g[i]) begin n_fail++; $display("FAIL fair_grant_%0d got %0h want %0h", i, grants[i], expect_g[i]); end
        end
`ifdef ARB_FIXED_PRIO_EN
        n_checks++; if (p0_saw_ready !== 1'b0) begin n_fail++; $display("FAIL fair_p0_starved got %0h want 0", p0_saw_ready); end
`else
        n_checks++; if (p0_saw_ready !== 1'b1) begin n_fail++; $display("FAIL fair_p0_served got %0h want 1", p0_saw_ready); end
`endif
    endtask

    task automatic test_rw_same_port;
        bit got;
        do_reset();
        bk_rdata = 32'hFFFF_FFFF;
        p1_read_en = 1; p1_write_en = 1; p1_address = 32'h80; p1_write_data = 32'hCAFE_F00D;
        step();
        n_checks++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rw_mem_write_en got %0h want 1", mem_write_en); end
        n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL rw_mem_read_en got %0h want 0", mem_read_en); end
        n_checks++; if (mem_address !== 32'h80) begin n_fail++; $display("FAIL rw_mem_address got %0h want 80", mem_address); end
        n_checks++; if (mem_write_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_mem_write_data got %0h want cafef00d", mem_write_data); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (p1_ready === 1'b1) got = 1;
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rw_timeout got %0h want 1", got); end
        n_checks++; if (p1_read_data !== 32'h0) begin n_fail++; $display("FAIL rw_no_read_return got %0h want 0", p1_read_data); end
        clear_reqs();
        repeat (2) step();
    endtask

    task automatic test_mid_reset;
        p0_read_en = 1; p0_address = 32'h300;
        step();
        n_checks++; if (mem_read_en !== 1'b1) begin n_fail++; $display("FAIL midrst_started got %0h want 1", mem_read_en); end
        step();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (mem_read_en !== 1'b0) begin n_fail++; $display("FAIL midrst_read_en_drop got %0h want 0", mem_read_en); end
        n_checks++; if (mem_write_en !== 1'b0) begin n_fail++; $display("FAIL midrst_write_en_drop got %0h want 0", mem_write_en); end
        n_checks++; if (p0_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_p0_ready got %0h want 0", p0_ready); end
        #2 rst = 1'b1;
        step();
        n_checks++; if (mem_read_en !== 1'b1) begin n_fail++; $display("FAIL midrst_rearb_en got %0h want 1", mem_read_en); end
        n_checks++; if (mem_address !== 32'h300) begin n_fail++; $display("FAIL midrst_rearb_addr got %0h want 300", mem_address); end
        clear_reqs();
        repeat (6) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bk_rdata = 32'h0;
        rst      = 1'b0;
        clear_reqs();
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_rw_same_port();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
